mem_port_arbiter: RTL and testbench

- Arbitrates one shared single-port memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Drives the memory through a req/ack handshake and returns read data to each side.
- Generates the per-stage stall signals that freeze PC, IF/ID and later pipeline registers while the memory is busy.
- Applies data-side priority, with a starvation limiter so instruction fetch always makes progress.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data access has priority, but a starvation counter guarantees fetch progress.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic              if_abort_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_valid_o,
   output logic              if_stall_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_valid_o,
   output logic              dm_stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_IF_BUSY = 2'd1,
      ST_DM_BUSY = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

   state_e            state_q;
   logic [3:0]        starve_cnt_q;
   logic [3:0]        starve_cnt_d;
   logic              drop_q;
   logic              drop_d;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic              if_valid_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic              dm_valid_q;

   logic              starve_hit;
   logic              dm_grant;
   logic              if_grant;
   logic              req_lost;

   // Grant selection, starvation counter update and result-drop detection.
   always_comb begin
      starve_hit = if_req_i & (starve_cnt_q == STARVE_MAX);
      dm_grant   = dm_req_i & ~starve_hit;
      if_grant   = ~dm_grant & if_req_i & ~if_abort_i;

      // A requester leaving before its valid (abort, or a protocol error) forfeits the result.
      case (state_q)
         ST_IF_BUSY: req_lost = ~if_req_i | if_abort_i;
         ST_DM_BUSY: req_lost = ~dm_req_i;
         default:    req_lost = 1'b0;
      endcase
      drop_d = drop_q | req_lost;

      if (dm_grant) begin
         if (if_req_i) begin
            if (starve_cnt_q == STARVE_MAX) begin
               starve_cnt_d = starve_cnt_q;
            end else begin
               starve_cnt_d = starve_cnt_q + 4'd1;
            end
         end else begin
            starve_cnt_d = 4'd0;
         end
      end else if (if_grant) begin
         starve_cnt_d = 4'd0;
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   // Arbitration FSM with registered memory-side and response outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         starve_cnt_q <= 4'd0;
         drop_q       <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= {ADDR_W{1'b0}};
         mem_wdata_q  <= {DATA_W{1'b0}};
         if_rdata_q   <= {DATA_W{1'b0}};
         if_valid_q   <= 1'b0;
         dm_rdata_q   <= {DATA_W{1'b0}};
         dm_valid_q   <= 1'b0;
      end else begin
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               starve_cnt_q <= starve_cnt_d;
               if (dm_grant) begin
                  state_q     <= ST_DM_BUSY;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= dm_we_i;
                  mem_addr_q  <= dm_addr_i;
                  mem_wdata_q <= dm_wdata_i;
               end else if (if_grant) begin
                  state_q     <= ST_IF_BUSY;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= if_addr_i;
                  mem_wdata_q <= {DATA_W{1'b0}};
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_IF_BUSY: begin
               drop_q <= drop_d;
               if (mem_ack_i) begin
                  mem_req_q <= 1'b0;
                  state_q   <= ST_RESP;
                  if (!drop_d) begin
                     if_rdata_q <= mem_rdata_i;
                     if_valid_q <= 1'b1;
                  end
               end
            end
            ST_DM_BUSY: begin
               drop_q <= drop_d;
               if (mem_ack_i) begin
                  mem_req_q <= 1'b0;
                  state_q   <= ST_RESP;
                  if (!drop_d) begin
                     dm_rdata_q <= mem_rdata_i;
                     dm_valid_q <= 1'b1;
                  end
               end
            end
            ST_RESP: begin
               drop_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q   <= ST_IDLE;
               mem_req_q <= 1'b0;
               drop_q    <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign if_rdata_o  = if_rdata_q;
   // A flush arriving in the response cycle still kills the fetch pulse.
   assign if_valid_o  = if_valid_q & ~if_abort_i;
   assign dm_rdata_o  = dm_rdata_q;
   assign dm_valid_o  = dm_valid_q;
   assign dm_stall_o  = dm_req_i & ~dm_valid_o;
   assign if_stall_o  = (if_req_i & ~if_valid_o) | dm_stall_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory that acks
// a configurable number of cycles after mem_req_o rises.
module tb_mem_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_abort_i;
   logic [31:0] if_rdata_o;
   logic        if_valid_o;
   logic        if_stall_o;
   logic        dm_req_i;
   logic        dm_we_i;
   logic [31:0] dm_addr_i;
   logic [31:0] dm_wdata_i;
   logic [31:0] dm_rdata_o;
   logic        dm_valid_o;
   logic        dm_stall_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   int          tests = 0;
   int          fails = 0;
   int          ack_dly = 1;
   int          wait_cnt = 0;
   logic [31:0] last_wdata = 32'h0;

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_abort_i(if_abort_i),
      .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o), .dm_stall_o(dm_stall_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
   );

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      case (a)
         32'h0000_0040: return 32'hDEAD_BEEF;
         32'h0000_0100: return 32'h1111_1111;
         32'h0000_0200: return 32'h2222_2222;
         default:       return a ^ 32'hC0DE_0000;
      endcase
   endfunction

   // Memory responder: ack after ack_dly cycles of mem_req_o, for one cycle.
   initial begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'h0;
      forever begin
         @(posedge clk_i);
         #1;
         if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            wait_cnt  = 0;
         end else if (mem_req_o) begin
            wait_cnt++;
            if (wait_cnt >= ack_dly) begin
               mem_ack_i   = 1'b1;
               mem_rdata_i = mem_data(mem_addr_o);
               if (mem_we_o) last_wdata = mem_wdata_o;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = 32'h0; if_abort_i = 1'b0;
      dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
      repeat (3) tick();
      #1;
      tests++;
      if ({mem_req_o, mem_we_o, if_valid_o, dm_valid_o, if_stall_o, dm_stall_o} !== 6'b0) begin
         fails++;
         $display("FAIL reset_ctl: got %b want 000000",
                  {mem_req_o, mem_we_o, if_valid_o, dm_valid_o, if_stall_o, dm_stall_o});
      end
      tests++;
      if ({mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o} !== 128'h0) begin
         fails++;
         $display("FAIL reset_data: addr %h wdata %h ird %h drd %h want 0",
                  mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o);
      end
      tests++;
      if (dut.starve_cnt_q !== 4'd0 || dut.drop_q !== 1'b0 || 2'(dut.state_q) !== 2'd0) begin
         fails++;
         $display("FAIL reset_state: starve %0d drop %b state %0d want 0 0 0",
                  dut.starve_cnt_q, dut.drop_q, dut.state_q);
      end
      rst_i = 1'b0;
      tick();
      #1;
      tests++;
      if (mem_req_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle: mem_req %b want 0", mem_req_o);
      end
   endtask

   task automatic test_single_load();
      logic [7:0] e_req, e_val, e_stl;
      e_req = 8'b0000_1110; e_val = 8'b0001_0000; e_stl = 8'b0000_1111;
      ack_dly = 3;
      for (int c = 0; c < 8; c++) begin
         if (c == 0) begin
            dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40;
         end
         #1;
         tests++;
         if ({mem_req_o, dm_valid_o, dm_stall_o} !== {e_req[c], e_val[c], e_stl[c]}) begin
            fails++;
            $display("FAIL load_c%0d: req/valid/stall %b want %b", c,
                     {mem_req_o, dm_valid_o, dm_stall_o}, {e_req[c], e_val[c], e_stl[c]});
         end
         if (c == 1) begin
            tests++;
            if (mem_addr_o !== 32'h40 || mem_we_o !== 1'b0) begin
               fails++;
               $display("FAIL load_addr: addr %h we %b want 00000040 0", mem_addr_o, mem_we_o);
            end
         end
         if (c == 4) begin
            tests++;
            if (dm_rdata_o !== 32'hDEAD_BEEF) begin
               fails++;
               $display("FAIL load_data: got %h want deadbeef", dm_rdata_o);
            end
         end
         if (dm_valid_o) dm_req_i = 1'b0;
         tick();
      end
   endtask

   task automatic test_contention();
      logic [7:0] e_req, e_dv, e_iv, e_is, e_ds;
      e_req = 8'b0001_0010; e_dv = 8'b0000_0100; e_iv = 8'b0010_0000;
      e_is  = 8'b0001_1111; e_ds = 8'b0000_0011;
      ack_dly = 1;
      for (int c = 0; c < 7; c++) begin
         if (c == 0) begin
            if_req_i = 1'b1; if_addr_i = 32'h300;
            dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h44;
         end
         #1;
         tests++;
         if ({mem_req_o, dm_valid_o, if_valid_o, if_stall_o, dm_stall_o} !==
             {e_req[c], e_dv[c], e_iv[c], e_is[c], e_ds[c]}) begin
            fails++;
            $display("FAIL cont_c%0d: req/dv/iv/is/ds %b want %b", c,
                     {mem_req_o, dm_valid_o, if_valid_o, if_stall_o, dm_stall_o},
                     {e_req[c], e_dv[c], e_iv[c], e_is[c], e_ds[c]});
         end
         if (c == 1) begin
            tests++;
            if (mem_addr_o !== 32'h44 || dut.starve_cnt_q !== 4'd1) begin
               fails++;
               $display("FAIL cont_dm_grant: addr %h starve %0d want 00000044 1",
                        mem_addr_o, dut.starve_cnt_q);
            end
         end
         if (c == 4) begin
            tests++;
            if (mem_addr_o !== 32'h300 || mem_we_o !== 1'b0 || dut.starve_cnt_q !== 4'd0) begin
               fails++;
               $display("FAIL cont_if_grant: addr %h we %b starve %0d want 00000300 0 0",
                        mem_addr_o, mem_we_o, dut.starve_cnt_q);
            end
         end
         if (c == 5) begin
            tests++;
            if (if_rdata_o !== 32'hC0DE_0300) begin
               fails++;
               $display("FAIL cont_if_data: got %h want c0de0300", if_rdata_o);
            end
         end
         if (dm_valid_o) dm_req_i = 1'b0;
         if (if_valid_o) if_req_i = 1'b0;
         tick();
      end
   endtask

   task automatic test_starvation();
      int dm_cnt = 0;
      int max_st = 0;
      logic if_seen = 1'b0;
      logic done = 1'b0;
      ack_dly = 1;
      if_req_i = 1'b1; if_addr_i = 32'h500;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h48;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (int'(dut.starve_cnt_q) > max_st) max_st = int'(dut.starve_cnt_q);
         if (dm_valid_o) begin
            if (if_seen) begin
               dm_req_i = 1'b0;
               done = 1'b1;
            end else begin
               dm_cnt++;
            end
         end
         if (if_valid_o && !if_seen) begin
            if_seen = 1'b1;
            if_req_i = 1'b0;
            tests++;
            if (dm_cnt != 4 || dut.starve_cnt_q !== 4'd0 || if_rdata_o !== 32'hC0DE_0500) begin
               fails++;
               $display("FAIL starve_if: dm grants %0d starve %0d data %h want 4 0 c0de0500",
                        dm_cnt, dut.starve_cnt_q, if_rdata_o);
            end
         end
         tick();
         if (done) break;
      end
      tests++;
      if (!if_seen || !done || max_st != 4) begin
         fails++;
         $display("FAIL starve_end: if_seen %b done %b max starve %0d want 1 1 4",
                  if_seen, done, max_st);
      end
      tick();
   endtask

   task automatic test_abort();
      logic [7:0] e_req;
      int n = 0;
      e_req = 8'b0000_1110;
      ack_dly = 3;
      for (int c = 0; c < 6; c++) begin
         if (c == 0) begin
            if_req_i = 1'b1; if_addr_i = 32'h100;
         end
         if (c == 2) begin
            if_abort_i = 1'b1; if_req_i = 1'b0;
         end
         if (c == 3) if_abort_i = 1'b0;
         #1;
         tests++;
         if ({mem_req_o, if_valid_o} !== {e_req[c], 1'b0}) begin
            fails++;
            $display("FAIL abort_c%0d: req/ivalid %b want %b", c,
                     {mem_req_o, if_valid_o}, {e_req[c], 1'b0});
         end
         if (c == 1) begin
            tests++;
            if (mem_addr_o !== 32'h100) begin
               fails++;
               $display("FAIL abort_addr: got %h want 00000100", mem_addr_o);
            end
         end
         tick();
      end
      #1;
      tests++;
      if (if_rdata_o !== 32'hC0DE_0500 || dut.drop_q !== 1'b0) begin
         fails++;
         $display("FAIL abort_keep: rdata %h drop %b want c0de0500 0", if_rdata_o, dut.drop_q);
      end
      ack_dly = 1;
      if_req_i = 1'b1; if_addr_i = 32'h200;
      while (n < 10 && !if_valid_o) begin
         tick();
         n++;
      end
      tests++;
      if (!if_valid_o || n != 2 || if_rdata_o !== 32'h2222_2222) begin
         fails++;
         $display("FAIL abort_refetch: valid %b after %0d data %h want 1 2 22222222",
                  if_valid_o, n, if_rdata_o);
      end
      if_req_i = 1'b0;
      tick();
   endtask

   task automatic test_store();
      logic [7:0] e_req, e_val;
      int pulses = 0;
      e_req = 8'b0000_1110; e_val = 8'b0001_0000;
      ack_dly = 3;
      for (int c = 0; c < 8; c++) begin
         if (c == 0) begin
            dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h80; dm_wdata_i = 32'h1234_5678;
         end
         if (c == 2) dm_wdata_i = 32'h0;
         #1;
         tests++;
         if ({mem_req_o, dm_valid_o} !== {e_req[c], e_val[c]}) begin
            fails++;
            $display("FAIL store_c%0d: req/valid %b want %b", c,
                     {mem_req_o, dm_valid_o}, {e_req[c], e_val[c]});
         end
         if (c >= 1 && c <= 3) begin
            tests++;
            if (mem_we_o !== 1'b1 || mem_wdata_o !== 32'h1234_5678 || mem_addr_o !== 32'h80) begin
               fails++;
               $display("FAIL store_hold_c%0d: we %b wdata %h addr %h want 1 12345678 00000080",
                        c, mem_we_o, mem_wdata_o, mem_addr_o);
            end
         end
         if (dm_valid_o) begin
            pulses++;
            dm_req_i = 1'b0; dm_we_i = 1'b0;
         end
         tick();
      end
      tests++;
      if (pulses != 1 || last_wdata !== 32'h1234_5678) begin
         fails++;
         $display("FAIL store_done: pulses %0d mem wrote %h want 1 12345678", pulses, last_wdata);
      end
   endtask

   task automatic test_reset_mid();
      ack_dly = 20;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h60;
      tick();
      tick();
      #1;
      tests++;
      if (mem_req_o !== 1'b1 || 2'(dut.state_q) !== 2'd2) begin
         fails++;
         $display("FAIL rstmid_busy: req %b state %0d want 1 2", mem_req_o, dut.state_q);
      end
      rst_i = 1'b1; dm_req_i = 1'b0;
      tick();
      rst_i = 1'b0;
      #1;
      tests++;
      if ({mem_req_o, dm_valid_o, if_valid_o, dm_stall_o, if_stall_o} !== 5'b0 ||
          2'(dut.state_q) !== 2'd0) begin
         fails++;
         $display("FAIL rstmid_after: req/dv/iv/ds/is %b state %0d want 00000 0",
                  {mem_req_o, dm_valid_o, if_valid_o, dm_stall_o, if_stall_o}, dut.state_q);
      end
      tick();
      #1;
      tests++;
      if ({mem_req_o, dm_valid_o, if_valid_o} !== 3'b0) begin
         fails++;
         $display("FAIL rstmid_quiet: req/dv/iv %b want 000", {mem_req_o, dm_valid_o, if_valid_o});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_load();
      test_contention();
      test_starvation();
      test_abort();
      test_store();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
